// File: rtl/wf_window_animator_pkg.sv
// Shared constants and types for the waveform window animator and its
// neighbours (window-limits selector, renderer).
package wf_window_animator_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    // Window shown out of reset
    localparam logic [X_W-1:0] DEF_START_X = 11'd380;
    localparam logic [X_W-1:0] DEF_END_X   = 11'd640;
    localparam logic [Y_W-1:0] DEF_START_Y = 10'd92;
    localparam logic [Y_W-1:0] DEF_END_Y   = 10'd452;

    // Full-screen window, also used by the selector
    localparam logic [X_W-1:0] FULL_START_X = 11'd88;
    localparam logic [X_W-1:0] FULL_END_X   = 11'd888;
    localparam logic [Y_W-1:0] FULL_START_Y = 10'd30;
    localparam logic [Y_W-1:0] FULL_END_Y   = 10'd512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ANIM = 1'b1
    } anim_state_t;

endpackage

// File: rtl/wf_window_animator_axis.sv
// Single-coordinate stepper: computes the next displayed value, moving the
// current value toward the target by at most STEP, landing exactly on the
// target when it is within reach.  Purely combinational; the register lives
// in the parent.
module wf_axis_stepper
    import wf_window_animator_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int STEP  = 8
) (
    input  logic             enable,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] cur_q,
    output logic [WIDTH-1:0] cur_d,
    output logic             at_target
);

    localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0]      STEP_U = WIDTH'(STEP);

    logic signed [WIDTH:0] diff;

    // Clamp a move to +/-STEP; never overshoots so no wrap is possible
    function automatic logic [WIDTH-1:0] step_toward(
        input logic [WIDTH-1:0]  c,
        input logic [WIDTH-1:0]  t,
        input logic signed [WIDTH:0] d
    );
        if (d > STEP_S)
            return c + STEP_U;
        else if (d < -STEP_S)
            return c - STEP_U;
        else
            return t;
    endfunction

    // Signed distance to target and the resulting next value
    always_comb begin
        diff      = $signed({1'b0, tgt}) - $signed({1'b0, cur_q});
        at_target = (diff == '0);
        cur_d     = enable ? step_toward(cur_q, tgt, diff) : cur_q;
    end

endmodule

// File: rtl/wf_window_animator.sv
// Moves the displayed waveform window toward the selector's target in fixed
// pixel steps, one step per FRAME_DIV accepted frame ticks, so zoom changes
// animate instead of jumping and never tear mid-frame.
module wf_window_animator
    import wf_window_animator_pkg::*;
#(
    parameter int STEP_X    = 8,
    parameter int STEP_Y    = 6,
    parameter int FRAME_DIV = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           freeze,
    input  logic [X_W-1:0] tgt_start_x,
    input  logic [X_W-1:0] tgt_end_x,
    input  logic [Y_W-1:0] tgt_start_y,
    input  logic [Y_W-1:0] tgt_end_y,
    output logic [X_W-1:0] cur_start_x,
    output logic [X_W-1:0] cur_end_x,
    output logic [Y_W-1:0] cur_start_y,
    output logic [Y_W-1:0] cur_end_y,
    output logic           busy,
    output logic           settled
);

    localparam int              DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    anim_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             busy_q, busy_d;
    logic             settled_q, settled_d;
    logic             step_en;

    logic [X_W-1:0] cur_start_x_q, cur_start_x_d;
    logic [X_W-1:0] cur_end_x_q, cur_end_x_d;
    logic [Y_W-1:0] cur_start_y_q, cur_start_y_d;
    logic [Y_W-1:0] cur_end_y_q, cur_end_y_d;
    logic           at_sx, at_ex, at_sy, at_ey;
    logic           all_at;

    wf_axis_stepper #(.WIDTH(X_W), .STEP(STEP_X)) u_start_x (
        .enable(step_en), .tgt(tgt_start_x), .cur_q(cur_start_x_q),
        .cur_d(cur_start_x_d), .at_target(at_sx)
    );
    wf_axis_stepper #(.WIDTH(X_W), .STEP(STEP_X)) u_end_x (
        .enable(step_en), .tgt(tgt_end_x), .cur_q(cur_end_x_q),
        .cur_d(cur_end_x_d), .at_target(at_ex)
    );
    wf_axis_stepper #(.WIDTH(Y_W), .STEP(STEP_Y)) u_start_y (
        .enable(step_en), .tgt(tgt_start_y), .cur_q(cur_start_y_q),
        .cur_d(cur_start_y_d), .at_target(at_sy)
    );
    wf_axis_stepper #(.WIDTH(Y_W), .STEP(STEP_Y)) u_end_y (
        .enable(step_en), .tgt(tgt_end_y), .cur_q(cur_end_y_q),
        .cur_d(cur_end_y_d), .at_target(at_ey)
    );

    assign all_at = at_sx & at_ex & at_sy & at_ey;

    // FSM next state, frame divider and step enable; targets are live inputs
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        busy_d    = busy_q;
        settled_d = 1'b0;
        step_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A tick on this cycle is deliberately not used for a step
                if (!all_at) begin
                    state_d = ST_ANIM;
                    busy_d  = 1'b1;
                end
            end
            ST_ANIM: begin
                if (all_at) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    settled_d = 1'b1;
                    div_cnt_d = '0;
                end else if (frame_tick && !freeze) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        step_en   = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State, divider, status flags and displayed window registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            busy_q        <= 1'b0;
            settled_q     <= 1'b0;
            cur_start_x_q <= DEF_START_X;
            cur_end_x_q   <= DEF_END_X;
            cur_start_y_q <= DEF_START_Y;
            cur_end_y_q   <= DEF_END_Y;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            busy_q        <= busy_d;
            settled_q     <= settled_d;
            cur_start_x_q <= cur_start_x_d;
            cur_end_x_q   <= cur_end_x_d;
            cur_start_y_q <= cur_start_y_d;
            cur_end_y_q   <= cur_end_y_d;
        end
    end

    assign cur_start_x = cur_start_x_q;
    assign cur_end_x   = cur_end_x_q;
    assign cur_start_y = cur_start_y_q;
    assign cur_end_y   = cur_end_y_q;
    assign busy        = busy_q;
    assign settled     = settled_q;

endmodule

// File: tb/tb_wf_window_animator.sv
// Bench for wf_window_animator: two instances (FRAME_DIV 1 and 3) share the
// stimulus; a reference model predicts every cycle's outputs into queues
// that an independent monitor drains, plus directed milestone checks.
module tb_wf_window_animator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        freeze = 1'b0;
    logic [10:0] tgt_start_x = 11'd380;
    logic [10:0] tgt_end_x   = 11'd640;
    logic [9:0]  tgt_start_y = 10'd92;
    logic [9:0]  tgt_end_y   = 10'd452;

    logic [10:0] o1_sx, o1_ex, o3_sx, o3_ex;
    logic [9:0]  o1_sy, o1_ey, o3_sy, o3_ey;
    logic        o1_busy, o1_settled, o3_busy, o3_settled;

    always #5 clk = ~clk;

    wf_window_animator #(.STEP_X(8), .STEP_Y(6), .FRAME_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .freeze(freeze),
        .tgt_start_x(tgt_start_x), .tgt_end_x(tgt_end_x),
        .tgt_start_y(tgt_start_y), .tgt_end_y(tgt_end_y),
        .cur_start_x(o1_sx), .cur_end_x(o1_ex),
        .cur_start_y(o1_sy), .cur_end_y(o1_ey),
        .busy(o1_busy), .settled(o1_settled)
    );

    wf_window_animator #(.STEP_X(8), .STEP_Y(6), .FRAME_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .freeze(freeze),
        .tgt_start_x(tgt_start_x), .tgt_end_x(tgt_end_x),
        .tgt_start_y(tgt_start_y), .tgt_end_y(tgt_end_y),
        .cur_start_x(o3_sx), .cur_end_x(o3_ex),
        .cur_start_y(o3_sy), .cur_end_y(o3_ey),
        .busy(o3_busy), .settled(o3_settled)
    );

    typedef struct packed {
        logic [10:0] sx;
        logic [10:0] ex;
        logic [9:0]  sy;
        logic [9:0]  ey;
        logic        busy;
        logic        settled;
    } obs_t;

    obs_t q1[$];
    obs_t q3[$];

    // Reference model state: window as plain integers, moving flag, tick count
    int  m_cur[2][4];
    bit  m_moving[2];
    int  m_ticks[2];

    int n_chk = 0;
    int n_fail = 0;
    int settled_cnt1 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clip_move(input int cur, input int tgt, input int lim);
        int d;
        d = tgt - cur;
        if (d > lim) return cur + lim;
        if (d < -lim) return cur - lim;
        return tgt;
    endfunction

    // Predict the outputs after the coming clock edge from the current inputs
    task automatic model_step();
        int   tg[4];
        int   lim[4];
        int   fd[2];
        bit   same;
        bit   pulse;
        obs_t e;
        tg  = '{int'(tgt_start_x), int'(tgt_end_x), int'(tgt_start_y), int'(tgt_end_y)};
        lim = '{8, 8, 6, 6};
        fd  = '{1, 3};
        for (int d = 0; d < 2; d++) begin
            pulse = 1'b0;
            if (rst) begin
                m_cur[d]    = '{380, 640, 92, 452};
                m_moving[d] = 1'b0;
                m_ticks[d]  = 0;
            end else begin
                same = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (m_cur[d][i] != tg[i]) same = 1'b0;
                if (!m_moving[d]) begin
                    m_moving[d] = !same;
                end else if (same) begin
                    m_moving[d] = 1'b0;
                    pulse       = 1'b1;
                    m_ticks[d]  = 0;
                end else if (frame_tick && !freeze) begin
                    m_ticks[d]++;
                    if (m_ticks[d] == fd[d]) begin
                        m_ticks[d] = 0;
                        for (int i = 0; i < 4; i++)
                            m_cur[d][i] = clip_move(m_cur[d][i], tg[i], lim[i]);
                    end
                end
            end
            e.sx      = 11'(m_cur[d][0]);
            e.ex      = 11'(m_cur[d][1]);
            e.sy      = 10'(m_cur[d][2]);
            e.ey      = 10'(m_cur[d][3]);
            e.busy    = m_moving[d];
            e.settled = pulse;
            if (d == 0) q1.push_back(e);
            else        q3.push_back(e);
        end
    endtask

    // One clock: inputs are already set at this negedge; predict, then advance
    task automatic cyc(input bit tick);
        frame_tick = tick;
        model_step();
        @(negedge clk);
    endtask

    task automatic tick3();
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
    endtask

    task automatic set_tgt(input int sx, input int ex, input int sy, input int ey);
        tgt_start_x = 11'(sx);
        tgt_end_x   = 11'(ex);
        tgt_start_y = 10'(sy);
        tgt_end_y   = 10'(ey);
    endtask

    task automatic do_reset();
        set_tgt(380, 640, 92, 452);
        freeze = 1'b0;
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        cyc(1'b0);
    endtask

    // Monitor: compare every DUT cycle against the predicted queue entries
    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {o1_sx, o1_ex, o1_sy, o1_ey, o1_busy, o1_settled};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL div1 cycle @%0t: got %0d/%0d/%0d/%0d busy=%0b settled=%0b, expected %0d/%0d/%0d/%0d busy=%0b settled=%0b",
                             $time, a.sx, a.ex, a.sy, a.ey, a.busy, a.settled,
                             e.sx, e.ex, e.sy, e.ey, e.busy, e.settled);
                end
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                a = {o3_sx, o3_ex, o3_sy, o3_ey, o3_busy, o3_settled};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL div3 cycle @%0t: got %0d/%0d/%0d/%0d busy=%0b settled=%0b, expected %0d/%0d/%0d/%0d busy=%0b settled=%0b",
                             $time, a.sx, a.ex, a.sy, a.ey, a.busy, a.settled,
                             e.sx, e.ex, e.sy, e.ey, e.busy, e.settled);
                end
            end
            if (o1_settled === 1'b1) settled_cnt1++;
        end
    end

    // Stimulus
    initial begin : stim
        int base;
        int done;
        int sx, ex, sy, ey;
        int exp4[3];
        int exp3[6];

        @(negedge clk);
        cyc(1'b0);
        cyc(1'b0);
        chk("reset start_x", o1_sx, 380);
        chk("reset end_x", o1_ex, 640);
        chk("reset start_y", o1_sy, 92);
        chk("reset end_y", o1_ey, 452);
        chk("reset busy", o1_busy, 0);
        chk("reset settled", o1_settled, 0);
        rst = 1'b0;
        cyc(1'b0);

        // Target equals default: ticks must not start an animation
        base = settled_cnt1;
        repeat (10) tick3();
        chk("idle busy", o1_busy, 0);
        chk("idle settled count", settled_cnt1 - base, 0);

        // Full-screen zoom
        base = settled_cnt1;
        set_tgt(88, 888, 30, 512);
        cyc(1'b0);
        chk("busy after retarget", o1_busy, 1);
        cyc(1'b0);
        done = 0;
        for (int k = 1; k <= 80 && done == 0; k++) begin
            tick3();
            if (k == 1) begin
                chk("tick1 start_x", o1_sx, 372);
                chk("tick1 end_x", o1_ex, 648);
                chk("tick1 start_y", o1_sy, 86);
                chk("tick1 end_y", o1_ey, 458);
            end
            if (k == 10) chk("tick10 end_y", o1_ey, 512);
            if (k == 11) chk("tick11 start_y", o1_sy, 30);
            if (k == 31) chk("tick31 end_x", o1_ex, 888);
            if (!o1_busy) done = k;
        end
        chk("zoom settle tick", done, 37);
        chk("zoom settled count", settled_cnt1 - base, 1);
        chk("zoom final start_x", o1_sx, 88);

        // Same zoom with freeze across ticks 5..9
        do_reset();
        set_tgt(88, 888, 30, 512);
        cyc(1'b0);
        cyc(1'b0);
        done = 0;
        for (int k = 1; k <= 90 && done == 0; k++) begin
            freeze = (k >= 5 && k <= 9);
            tick3();
            if (k == 9) begin
                chk("frozen start_x", o1_sx, 348);
                chk("frozen end_x", o1_ex, 672);
                chk("frozen start_y", o1_sy, 68);
                chk("frozen end_y", o1_ey, 476);
            end
            if (!o1_busy) done = k;
        end
        freeze = 1'b0;
        chk("freeze settle tick", done, 42);

        // Retarget back to default mid-animation
        do_reset();
        base = settled_cnt1;
        set_tgt(88, 888, 30, 512);
        cyc(1'b0);
        cyc(1'b0);
        repeat (3) tick3();
        chk("retarget start_x before", o1_sx, 356);
        set_tgt(380, 640, 92, 452);
        exp4 = '{364, 372, 380};
        for (int i = 0; i < 3; i++) begin
            tick3();
            chk("retarget start_x", o1_sx, exp4[i]);
        end
        chk("retarget busy", o1_busy, 0);
        chk("retarget settled count", settled_cnt1 - base, 1);

        // Frame divider of 3 on the second instance
        do_reset();
        set_tgt(364, 640, 92, 452);
        cyc(1'b0);
        cyc(1'b0);
        exp3 = '{380, 380, 372, 372, 372, 364};
        for (int k = 0; k < 6; k++) begin
            tick3();
            chk("div3 start_x", o3_sx, exp3[k]);
            if (k == 4) chk("div3 busy before last", o3_busy, 1);
        end
        chk("div3 busy after", o3_busy, 0);

        // Reset mid-animation: immediate default, no settled pulse
        do_reset();
        set_tgt(88, 888, 30, 512);
        cyc(1'b0);
        cyc(1'b0);
        repeat (5) tick3();
        base = settled_cnt1;
        set_tgt(380, 640, 92, 452);
        rst = 1'b1;
        #1;
        chk("async reset start_x", o1_sx, 380);
        chk("async reset end_y", o1_ey, 452);
        cyc(1'b0);
        rst = 1'b0;
        repeat (3) cyc(1'b0);
        chk("reset settled count", settled_cnt1 - base, 0);
        chk("reset busy", o1_busy, 0);

        // Target within one step lands in a single tick
        set_tgt(376, 640, 92, 452);
        cyc(1'b0);
        cyc(1'b0);
        tick3();
        chk("small step start_x", o1_sx, 376);
        chk("small step busy", o1_busy, 0);

        // Randomized traffic, checked cycle by cycle through the scoreboard
        do_reset();
        repeat (2500) begin
            if ($urandom_range(0, 59) == 0) begin
                sx = $urandom_range(0, 1200);
                ex = $urandom_range(sx + 1, 2047);
                sy = $urandom_range(0, 900);
                ey = $urandom_range(sy + 1, 1023);
                if ($urandom_range(0, 2) == 0) begin
                    sx = int'(tgt_start_x) + $urandom_range(0, 20) - 10;
                    if (sx < 0) sx = 0;
                    ex = int'(tgt_end_x);
                    if (ex <= sx) ex = sx + 1;
                    sy = int'(tgt_start_y);
                    ey = int'(tgt_end_y);
                end
                set_tgt(sx, ex, sy, ey);
            end
            if ($urandom_range(0, 19) == 0) freeze = ~freeze;
            rst = ($urandom_range(0, 399) == 0);
            cyc($urandom_range(0, 1) == 0);
        end
        rst = 1'b0;
        freeze = 1'b0;
        repeat (3) cyc(1'b0);
        for (int i = 0; i < 10 && (q1.size() > 0 || q3.size() > 0); i++)
            @(negedge clk);
        chk("scoreboard drained", q1.size() + q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
